// File: rtl/simon_pkg.sv
// Shared Simon engine constants: FSM state codes, LFSR seed/taps, score ceiling, win blink period.
package simon_pkg;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_ADD      = 3'd1,
    ST_PLAY_ON  = 3'd2,
    ST_PLAY_GAP = 3'd3,
    ST_WAIT_IN  = 3'd4,
    ST_WIN      = 3'd5,
    ST_LOSE     = 3'd6
  } state_e;

  localparam logic [15:0] LFSR_SEED     = 16'hACE1;
  // x^16 + x^14 + x^13 + x^11 + 1, maximal length
  localparam logic [15:0] LFSR_TAPS     = 16'hB400;
  localparam logic [9:0]  SCORE_MAX     = 10'd999;
  localparam int          WIN_TOGGLE_MS = 250;

  function automatic logic [15:0] lfsr_next(input logic [15:0] q);
    return {q[14:0], ^(q & LFSR_TAPS)};
  endfunction

endpackage

// File: rtl/simon_seq_engine_if.sv
// Pin bundle between the Simon engine and its board: timing base, start, buttons, lamps, tone, status.
interface simon_seq_engine_if #(parameter int N_CH = 4);

  logic [15:0]             TICKS_PER_MILLI;
  logic                    START;
  logic [N_CH-1:0]         BTN;
  logic [N_CH-1:0]         LED;
  logic [$clog2(N_CH)-1:0] TONE;
  logic                    SND_EN;
  logic [2:0]              STATE;
  logic [9:0]              SCORE;
  logic                    GAME_OVER;

  modport master (
    output TICKS_PER_MILLI, START, BTN,
    input  LED, TONE, SND_EN, STATE, SCORE, GAME_OVER
  );

  modport slave (
    input  TICKS_PER_MILLI, START, BTN,
    output LED, TONE, SND_EN, STATE, SCORE, GAME_OVER
  );

endinterface

// File: rtl/simon_ms_tick.sv
// Millisecond strobe: one-cycle pulse when the cycle counter reaches ticks_per_milli-1, then wraps.
// clr_i restarts the count so every FSM state begins on a clean millisecond boundary.
module simon_ms_tick (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        clr_i,
  input  logic [15:0] ticks_per_milli_i,
  output logic        tick_o
);

  logic [15:0] cnt_q, cnt_d;

  assign tick_o = (cnt_q == ticks_per_milli_i - 16'd1);

  always_comb begin
    cnt_d = cnt_q + 16'd1;
    if (clr_i || tick_o) cnt_d = '0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) cnt_q <= '0;
    else        cnt_q <= cnt_d;
  end

endmodule

// File: rtl/simon_seq_engine.sv
// Simon game engine: grows an LFSR-drawn sequence, plays it back on LEDs/tone, checks presses, keeps score.
// Defining SIMON_TIMEOUT_EN adds a per-element input timeout that ends the game from WAIT_IN.
module simon_seq_engine
  import simon_pkg::*;
#(
  parameter int N_CH       = 4,
  parameter int MAX_LEN    = 32,
  parameter int ON_MS      = 400,
  parameter int GAP_MS     = 200,
  parameter int END_MS     = 1000,
  parameter int TIMEOUT_MS = 3000
) (
  input logic               CLK,
  input logic               RST,
  simon_seq_engine_if.slave bus
);

  localparam int              CW      = $clog2(N_CH);
  localparam int              AW      = $clog2(MAX_LEN);
  localparam int              LW      = $clog2(MAX_LEN + 1);
  localparam logic [N_CH-1:0] CH_ONE  = N_CH'(1);
  localparam logic [LW-1:0]   LEN_ONE = LW'(1);
  localparam logic [LW-1:0]   LEN_MAX = LW'(MAX_LEN);

  if (N_CH < 2 || N_CH > 8 || MAX_LEN < 2 || MAX_LEN > 256 || ON_MS < 1 ||
      GAP_MS < 1 || END_MS < 1 || TIMEOUT_MS < 1) begin : g_param_check
    $error("simon_seq_engine: parameter out of legal range");
  end

  state_e          state_q, state_d;
  logic            start_q;
  logic [N_CH-1:0] btn_q;
  logic [15:0]     lfsr_q, lfsr_d;
  logic [15:0]     ms_q, ms_d;
  logic [LW-1:0]   len_q, idx_q;
  logic [9:0]      score_q;
  logic            done_q;
  logic            win_led_q;
  logic [CW-1:0]   mem [MAX_LEN];

  logic            tick, timer_clr, win_wrap;
  logic            start_rise, press, multi, good, last, on_end, gap_end;
  logic [N_CH-1:0] rise;
  logic [CW-1:0]   press_ch, held_ch, play_ch, new_ch;
  logic            held_one;
  logic [N_CH-1:0] led;
  logic [CW-1:0]   tone;
  logic            snd;

  function automatic logic [CW-1:0] ch_index(input logic [N_CH-1:0] v);
    logic [CW-1:0] r;
    r = '0;
    for (int i = 0; i < N_CH; i++) begin
      if (v[i]) r = CW'(i);
    end
    return r;
  endfunction

  simon_ms_tick u_tick (
    .clk              (CLK),
    .rst_n            (RST),
    .clr_i            (timer_clr),
    .ticks_per_milli_i(bus.TICKS_PER_MILLI),
    .tick_o           (tick)
  );

  assign start_rise = bus.START & ~start_q;
  assign rise       = bus.BTN & ~btn_q;
  assign press      = |rise;
  // Two or more rising bits in one cycle can never match a single element.
  assign multi      = (rise & (rise - CH_ONE)) != '0;
  assign press_ch   = ch_index(rise);
  assign held_ch    = ch_index(bus.BTN);
  assign held_one   = (bus.BTN != '0) && ((bus.BTN & (bus.BTN - CH_ONE)) == '0);
  assign play_ch    = mem[idx_q[AW-1:0]];
  assign good       = press && !multi && (press_ch == play_ch);
  assign last       = (idx_q == len_q - LEN_ONE);
  assign on_end     = tick && (ms_q == 16'(ON_MS - 1));
  assign gap_end    = tick && (ms_q == 16'(GAP_MS - 1));
  assign win_wrap   = (state_q == ST_WIN) && tick && (ms_q == 16'(WIN_TOGGLE_MS - 1));
  assign new_ch     = CW'(lfsr_q % 16'(N_CH));
  assign lfsr_d     = lfsr_next(lfsr_q);
  assign timer_clr  = (state_d != state_q) || ((state_q == ST_WAIT_IN) && press);

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) state_q <= ST_IDLE;
    else      state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE, ST_WIN, ST_LOSE: if (start_rise) state_d = ST_ADD;
      ST_ADD:                   state_d = ST_PLAY_ON;
      ST_PLAY_ON:               if (on_end) state_d = ST_PLAY_GAP;
      ST_PLAY_GAP: begin
        if (gap_end) state_d = ((idx_q + LEN_ONE) < len_q) ? ST_PLAY_ON : ST_WAIT_IN;
      end
      ST_WAIT_IN: begin
        if (done_q) begin
          if (bus.BTN == '0) state_d = (len_q < LEN_MAX) ? ST_ADD : ST_WIN;
        end else if (press) begin
          if (!good) state_d = ST_LOSE;
        end
`ifdef SIMON_TIMEOUT_EN
        else if (tick && (ms_q == 16'(TIMEOUT_MS - 1))) begin
          state_d = ST_LOSE;
        end
`endif
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    led  = '0;
    tone = '0;
    snd  = 1'b0;
    case (state_q)
      ST_PLAY_ON: begin
        led  = CH_ONE << play_ch;
        tone = play_ch;
        snd  = 1'b1;
      end
      ST_WAIT_IN: begin
        led = bus.BTN;
        if (held_one) begin
          tone = held_ch;
          snd  = 1'b1;
        end
      end
      ST_WIN:  led = {N_CH{win_led_q}};
      ST_LOSE: led = (ms_q < 16'(END_MS)) ? {N_CH{1'b1}} : '0;
      default: ;
    endcase
  end

  assign bus.LED       = led;
  assign bus.TONE      = tone;
  assign bus.SND_EN    = snd;
  assign bus.STATE     = state_q;
  assign bus.SCORE     = score_q;
  assign bus.GAME_OVER = (state_q == ST_WIN) || (state_q == ST_LOSE);

  // Saturates so the long LOSE indication needs no separate done flag.
  always_comb begin
    ms_d = ms_q;
    if (timer_clr || win_wrap)      ms_d = '0;
    else if (tick && ms_q != '1)    ms_d = ms_q + 16'd1;
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      start_q   <= 1'b0;
      btn_q     <= '0;
      lfsr_q    <= LFSR_SEED;
      ms_q      <= '0;
      win_led_q <= 1'b0;
    end else begin
      start_q <= bus.START;
      btn_q   <= bus.BTN;
      lfsr_q  <= lfsr_d;
      ms_q    <= ms_d;
      if (state_d == ST_WIN && state_q != ST_WIN) win_led_q <= 1'b1;
      else if (win_wrap)                          win_led_q <= ~win_led_q;
    end
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      len_q   <= '0;
      idx_q   <= '0;
      score_q <= '0;
      done_q  <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE, ST_WIN, ST_LOSE: begin
          if (start_rise) begin
            len_q   <= '0;
            idx_q   <= '0;
            score_q <= '0;
            done_q  <= 1'b0;
          end
        end
        ST_ADD: begin
          len_q  <= len_q + LEN_ONE;
          idx_q  <= '0;
          done_q <= 1'b0;
        end
        ST_PLAY_GAP: begin
          if (gap_end) idx_q <= ((idx_q + LEN_ONE) < len_q) ? idx_q + LEN_ONE : '0;
        end
        ST_WAIT_IN: begin
          if (!done_q && good) begin
            idx_q <= idx_q + LEN_ONE;
            if (last) begin
              done_q <= 1'b1;
              if (score_q < SCORE_MAX) score_q <= score_q + 10'd1;
            end
          end
        end
        default: ;
      endcase
    end
  end

  // Sequence memory holds no reset: a new game always rewrites before reading.
  always_ff @(posedge CLK) begin
    if (state_q == ST_ADD) mem[len_q[AW-1:0]] <= new_ch;
  end

endmodule
